// File: rtl/soqpsk_lut_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for the SOQPSK LUT arbiter.
package soqpsk_lut_pkg;

  localparam int SOQPSK_ROM_ADDR_W = 9;
  localparam int SOQPSK_ROM_DATA_W = 14;
  localparam int SOQPSK_ROM_LAT    = 2;

  // The pick function and tag index are sized for the largest supported requester count.
  localparam int RR_MAX_REQ = 8;
  localparam int TAG_IDX_W  = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } lut_tag_t;

  // Zero-padded upper requests never win, so wrapping modulo RR_MAX_REQ
  // visits the real requesters in the same order as wrapping modulo NUM_REQ.
  function automatic logic [RR_MAX_REQ-1:0] rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                                    input logic [TAG_IDX_W-1:0]  ptr);
    logic [RR_MAX_REQ-1:0] grant;
    logic                  found;
    logic [TAG_IDX_W-1:0]  idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      idx = ptr + TAG_IDX_W'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/soqpsk_lut_arbiter_if.sv
// Requester-side bus of the shared SOQPSK LUT: read requests in, tagged responses out.
interface soqpsk_lut_arbiter_if
  import soqpsk_lut_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SOQPSK_ROM_ADDR_W,
  parameter int DATA_W  = SOQPSK_ROM_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/soqpsk_lut_arbiter_rr_arbiter.sv
// Round-robin grant with a pointer that moves past the most recent winner.
module rr_arbiter
  import soqpsk_lut_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;

  // Grants are gated by reset_n so nothing handshakes while reset is held.
  always_comb begin
    grant = NUM_REQ'(rr_pick(RR_MAX_REQ'(req_valid), TAG_IDX_W'(ptr_q))) & {NUM_REQ{reset_n}};
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
    grant_any = |grant;
  end

  // A grant is only ever given to a valid requester, so any grant is a handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (grant_any) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/soqpsk_lut_arbiter.sv
// Shares one registered SOQPSK waveform ROM among NUM_REQ channels and
// steers each returned sample back to the requester that issued it.
module soqpsk_lut_arbiter
  import soqpsk_lut_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SOQPSK_ROM_ADDR_W,
  parameter int DATA_W  = SOQPSK_ROM_DATA_W,
  parameter int ROM_LAT = SOQPSK_ROM_LAT
) (
  input  logic                clock,
  input  logic                reset_n,
  soqpsk_lut_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [DATA_W-1:0]   rom_q,
  output logic                busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_any;
  logic [ADDR_W-1:0]           addr_sel;
  logic [ADDR_W-1:0]           last_addr_q;
  lut_tag_t [ROM_LAT-1:0]      tag_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Idle cycles replay the last granted address so the ROM input stays quiet.
  assign rom_address = grant_any ? addr_sel : last_addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_addr_q <= '0;
    end else if (grant_any) begin
      last_addr_q <= addr_sel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_any, index: TAG_IDX_W'(grant_idx)};
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = tag_q[ROM_LAT-1].valid && (tag_q[ROM_LAT-1].index == TAG_IDX_W'(i));
    end
  end

  assign bus.rsp_data = rom_q;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < ROM_LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end
endmodule

// File: tb/tb_soqpsk_lut_arbiter.sv
// Bench for soqpsk_lut_arbiter: grant/address vector table plus a response scoreboard.
module tb_soqpsk_lut_arbiter;
  import soqpsk_lut_pkg::*;

  localparam int NR = 4;
  localparam int AW = 9;
  localparam int DW = 14;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  soqpsk_lut_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;
  logic          busy;

  soqpsk_lut_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .busy        (busy)
  );

  // ROM model: registered address and registered output
  logic [DW-1:0] mem [512];
  logic [AW-1:0] rom_a_q;
  always @(posedge clock) begin
    rom_a_q <= rom_address;
    rom_q   <= mem[rom_a_q];
  end

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [NR-1:0]    valid;
    logic [NR*AW-1:0] addr;
    logic [NR-1:0]    ready;
    logic [AW-1:0]    rom;
    logic             busy;
  } vec_t;
  vec_t vq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rsp_cnt [NR];
  logic [NR*AW-1:0] addrs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [NR-1:0] v, input logic [NR-1:0] r, input logic [AW-1:0] a,
                     input logic b);
    vq.push_back('{valid: v, addr: addrs, ready: r, rom: a, busy: b});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.idx);
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
          rsp_cnt[e.idx]++;
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("rsp_missing", 32'(bus.rsp_valid), 32'd1 << e.idx);
      end
    end
  endtask

  task automatic push_proc();
    logic [NR-1:0]    pend;
    logic [NR*AW-1:0] paddr;
    pend  = '0;
    paddr = '0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        sbq.delete();
        pend = '0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (pend[i]) chk("addr_hold", 32'(bus.req_addr[i*AW +: AW]), 32'(paddr[i*AW +: AW]));
          if (bus.req_valid[i] && bus.req_ready[i])
            sbq.push_back('{idx: i, data: mem[bus.req_addr[i*AW +: AW]], due: cyc + 2});
        end
        cyc++;
        pend  = bus.req_valid & ~bus.req_ready;
        paddr = bus.req_addr;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sbq.size() != 0; k++) begin
      @(negedge clock);
      #1;
    end
    chk("sb_drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = DW'(a * 29 + 3);
    mem[9'h1A5] = 14'h2ABC;
    for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
    addrs = {9'h07F, 9'h1A5, 9'h122, 9'h011};
    bus.req_valid = '0;
    bus.req_addr  = addrs;

    add(4'b0000, 4'b0000, 9'h011, 1'b1);
    add(4'b0100, 4'b0100, 9'h1A5, 1'b1);
    add(4'b0000, 4'b0000, 9'h1A5, 1'b1);
    add(4'b0000, 4'b0000, 9'h1A5, 1'b1);
    add(4'b1000, 4'b1000, 9'h07F, 1'b0);
    add(4'b0000, 4'b0000, 9'h07F, 1'b1);
    for (int r = 0; r < 2; r++) begin
      add(4'b1111, 4'b0001, 9'h011, 1'b1);
      add(4'b1111, 4'b0010, 9'h122, 1'b1);
      add(4'b1111, 4'b0100, 9'h1A5, 1'b1);
      add(4'b1111, 4'b1000, 9'h07F, 1'b1);
    end
    add(4'b0010, 4'b0010, 9'h122, 1'b1);
    add(4'b1010, 4'b1000, 9'h07F, 1'b1);
    add(4'b0010, 4'b0010, 9'h122, 1'b1);
    add(4'b1111, 4'b0100, 9'h1A5, 1'b1);
    add(4'b0000, 4'b0000, 9'h1A5, 1'b1);

    fork
      monitor();
      push_proc();
    join_none

    // reset with every requester asking
    #2;
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clock);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("first_ready", 32'(bus.req_ready), 32'b0001);
    chk("first_rom_address", 32'(rom_address), 32'h011);
    @(negedge clock);

    foreach (vq[n]) begin
      bus.req_valid = vq[n].valid;
      bus.req_addr  = vq[n].addr;
      #1;
      chk($sformatf("vec%0d_ready", n), 32'(bus.req_ready), 32'(vq[n].ready));
      chk($sformatf("vec%0d_rom_address", n), 32'(rom_address), 32'(vq[n].rom));
      chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(vq[n].busy));
      @(negedge clock);
    end

    drain();
    @(negedge clock);
    #1;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rsp_cnt0", 32'(rsp_cnt[0]), 32'd3);
    chk("rsp_cnt1", 32'(rsp_cnt[1]), 32'd4);
    chk("rsp_cnt2", 32'(rsp_cnt[2]), 32'd4);
    chk("rsp_cnt3", 32'(rsp_cnt[3]), 32'd4);

    // reset pulse with two reads in flight
    @(negedge clock);
    bus.req_valid = 4'b0011;
    #1;
    chk("mid_ready_a", 32'(bus.req_ready), 32'b0001);
    chk("mid_rom_a", 32'(rom_address), 32'h011);
    @(negedge clock);
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_ready_b", 32'(bus.req_ready), 32'b0010);
    chk("mid_rom_b", 32'(rom_address), 32'h122);
    @(posedge clock);
    #1;
    reset_n       = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rom_address", 32'(rom_address), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);
    chk("post_rst_rom_address", 32'(rom_address), 32'h011);
    @(negedge clock);
    chk("post_rst_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd1);
    bus.req_valid = '0;
    #1;
    drain();
    chk("post_rst_cnt0", 32'(rsp_cnt[0]), 32'd4);
    chk("post_rst_cnt1", 32'(rsp_cnt[1]), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/soqpsk_lut_arbiter.md
Name: soqpsk_lut_arbiter

Overview:
Shares one SOQPSK waveform lookup ROM (512 x 14, registered address and output, 2-cycle read latency) between NUM_REQ modulator channels, for example the I/Q paths of several SOQPSK transmitters.
- Accepts one read per cycle from the requesters using round-robin arbitration.
- Drives the ROM address port.
- Tags each in-flight read so the returned sample is steered to the requester that issued it.
- Sits between the per-channel SOQPSK phase/sample sequencers and the shared ROM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ADDR_W, 9, ROM address width.
DATA_W, 14, ROM data width.
ROM_LAT, 2, clock edges from address sample to valid rom_q (matches address reg + output reg).

Ports:
clock  in  1  single system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester read request.
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both high at a rising edge.
rsp_valid  out  NUM_REQ  one-hot; marks the cycle in which rsp_data belongs to requester i.
rsp_data  out  DATA_W  ROM sample, routed through from rom_q.
rom_address  out  ADDR_W  to the ROM address input.
rom_q  in  DATA_W  from the ROM q output.
busy  out  1  high while any read is in flight.

Behaviour:
- Reset (async assert, sync release):
  - rr pointer = 0, tag pipeline cleared, last_addr = 0.
  - rsp_valid = 0 and busy = 0 immediately on assert.
  - req_ready = 0 while reset_n is low; rom_address = 0.
- Arbitration:
  - Combinational each cycle; search starts at the requester given by the pointer and wraps modulo NUM_REQ.
  - The first requester with req_valid high gets req_ready.
  - At most one req_ready bit is high; req_ready is never high for a requester whose req_valid is low.
  - If no requester is valid, req_ready = 0.
- Pointer update:
  - On a completed handshake with requester g, the pointer becomes (g+1) mod NUM_REQ.
  - With no handshake the pointer holds.
  - Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- Address:
  - rom_address = req_addr of the granted requester in a grant cycle.
  - Otherwise rom_address = last_addr, a register updated on each grant, so the ROM input never glitches to a non-requested value.
- Tag pipeline:
  - ROM_LAT-stage shift register of {valid, index[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {grant, g} at each edge.
  - rsp_valid[i] = last stage valid and index == i.
  - rsp_data = rom_q, combinational pass-through.
- Latency:
  - A handshake at edge T gives rsp_valid and rsp_data valid in the cycle after edge T+ROM_LAT-1.
  - With ROM_LAT = 2, data is sampled by the requester at edge T+2.
  - Fully pipelined: back-to-back grants give back-to-back responses in order, with no bubbles.
- Requester rule:
  - Once req_valid is raised, req_addr is held stable until the handshake.
  - The arbiter does not check this; verification asserts it.
- busy = OR of all tag pipeline valid bits.
- Reset mid-operation:
  - In-flight reads are discarded; no rsp_valid is produced for them after release.
  - The first grant after release is to the lowest-index valid requester.
- No backpressure on responses: requesters must accept rsp_valid in the cycle it is presented.

Decomposition:
- Package soqpsk_lut_pkg holds:
  - constants SOQPSK_ROM_ADDR_W = 9, SOQPSK_ROM_DATA_W = 14, SOQPSK_ROM_LAT = 2;
  - the tag struct/type {valid, index};
  - function rr_pick(valid, ptr), returning the one-hot grant.
- One sub-module, rr_arbiter: parameterised round-robin grant plus pointer register.
- soqpsk_lut_arbiter instantiates rr_arbiter and adds the address mux, last_addr register and tag pipeline.

Test Plan:
- Reset with all req_valid = 1 -> req_ready = 0000 while reset_n = 0; after release the first grant is 0001 and rom_address = req_addr[0].
- Single requester 2 issues address 0x1A5 at edge T, ROM model returns 0x2ABC -> rsp_valid = 0100 and rsp_data = 0x2ABC sampled at T+2; busy high for 2 cycles.
- All 4 requesters held valid for 8 cycles -> grants 0001, 0010, 0100, 1000, repeating; responses arrive in the same order with no gaps; each requester receives exactly 2 responses.
- Requesters 1 and 3 valid with pointer at 2 -> requester 3 granted first, then 1; the pointer ends at 2.
- Idle cycle after a grant of address 0x07F -> rom_address stays 0x07F and no rsp_valid is generated for the idle cycle.
- reset_n pulsed low one cycle after two back-to-back grants -> rsp_valid stays 0000 after release (both in-flight reads dropped); the next grant restarts at requester 0.
